// File: rtl/ghost_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ghost_pkg -- mode/heading encodings and packed renderer word
// Revision : 1.0 initial release
// ============================================================================
package ghost_pkg;

    localparam logic [1:0] C_MODE_NORM = 2'b00;
    localparam logic [1:0] C_MODE_FRGT = 2'b01;
    localparam logic [1:0] C_MODE_SCOR = 2'b10;
    localparam logic [1:0] C_MODE_DEAD = 2'b11;

    localparam logic [1:0] C_DIR_RT = 2'b00;
    localparam logic [1:0] C_DIR_UP = 2'b01;
    localparam logic [1:0] C_DIR_DN = 2'b10;
    localparam logic [1:0] C_DIR_LT = 2'b11;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic [1:0] mode;
        logic       flash;
    } ghost_inputs_t;

    // The heading encoding pairs opposites as bitwise complements.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return ~d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_mode_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ghost_mode_fsm -- ghost mode, frightened/score timers and flash
// Revision : 1.0 initial release
// ============================================================================
module ghost_mode_fsm
    import ghost_pkg::*;
#(
    parameter int FRGT_FRAMES  = 360,
    parameter int FLASH_START  = 120,
    parameter int FLASH_PERIOD = 16,
    parameter int SCOR_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick_i,
    input  logic       power_pellet_i,
    input  logic       eaten_i,
    input  logic       at_home_i,
    output logic [1:0] mode_o,
    output logic       flash_o,
    output logic       mode_changed_o
);

    localparam int FRGT_W = $clog2(FRGT_FRAMES + 1);
    localparam int SCOR_W = $clog2(SCOR_FRAMES + 1);
    localparam int FLSH_W = $clog2(FLASH_PERIOD + 1);

    localparam logic [FRGT_W-1:0] C_FRGT_LOAD   = FRGT_W'(FRGT_FRAMES);
    localparam logic [FRGT_W-1:0] C_FRGT_ONE    = FRGT_W'(1);
    localparam logic [FRGT_W-1:0] C_FLASH_START = FRGT_W'(FLASH_START);
    localparam logic [SCOR_W-1:0] C_SCOR_LOAD   = SCOR_W'(SCOR_FRAMES);
    localparam logic [SCOR_W-1:0] C_SCOR_ONE    = SCOR_W'(1);
    localparam logic [FLSH_W-1:0] C_FLASH_LAST  = FLSH_W'(FLASH_PERIOD - 1);

    logic [1:0]        mode_q,     mode_d;
    logic [FRGT_W-1:0] frgt_q,     frgt_d;
    logic [SCOR_W-1:0] scor_q,     scor_d;
    logic [FLSH_W-1:0] fcnt_q,     fcnt_d;
    logic              flash_q,    flash_d;
    logic              pend_pwr_q, pend_pwr_d;
    logic              pend_eat_q, pend_eat_d;

    always_comb begin
        mode_d     = mode_q;
        frgt_d     = frgt_q;
        scor_d     = scor_q;
        fcnt_d     = fcnt_q;
        flash_d    = flash_q;
        pend_pwr_d = pend_pwr_q | power_pellet_i;
        pend_eat_d = pend_eat_q | eaten_i;

        if (frame_tick_i) begin
            // A pulse landing on the tick cycle itself is held for the next frame.
            pend_pwr_d = power_pellet_i;
            pend_eat_d = eaten_i;

            case (mode_q)
                C_MODE_NORM: begin
                    if (pend_pwr_q) begin
                        mode_d = C_MODE_FRGT;
                        frgt_d = C_FRGT_LOAD;
                    end
                end
                C_MODE_FRGT: begin
                    if (pend_eat_q) begin
                        mode_d = C_MODE_SCOR;
                        scor_d = C_SCOR_LOAD;
                    end else if (pend_pwr_q) begin
                        frgt_d = C_FRGT_LOAD;
                    end else if (frgt_q == C_FRGT_ONE) begin
                        mode_d = C_MODE_NORM;
                    end else begin
                        frgt_d = frgt_q - C_FRGT_ONE;
                    end
                end
                C_MODE_SCOR: begin
                    if (scor_q == C_SCOR_ONE) begin
                        mode_d = C_MODE_DEAD;
                    end else begin
                        scor_d = scor_q - C_SCOR_ONE;
                    end
                end
                default: begin
                    if (at_home_i) begin
                        mode_d = C_MODE_NORM;
                    end
                end
            endcase

            // Flash phase restarts at 1 whenever the flashing window is entered.
            if ((mode_d != C_MODE_FRGT) || (frgt_d > C_FLASH_START)) begin
                flash_d = 1'b0;
                fcnt_d  = '0;
            end else if ((mode_q != C_MODE_FRGT) || (frgt_q > C_FLASH_START)) begin
                flash_d = 1'b1;
                fcnt_d  = '0;
            end else if (fcnt_q == C_FLASH_LAST) begin
                flash_d = ~flash_q;
                fcnt_d  = '0;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end

        mode_changed_o = frame_tick_i && (mode_d != mode_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= C_MODE_NORM;
            frgt_q     <= '0;
            scor_q     <= '0;
            fcnt_q     <= '0;
            flash_q    <= 1'b0;
            pend_pwr_q <= 1'b0;
            pend_eat_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            frgt_q     <= frgt_d;
            scor_q     <= scor_d;
            fcnt_q     <= fcnt_d;
            flash_q    <= flash_d;
            pend_pwr_q <= pend_pwr_d;
            pend_eat_q <= pend_eat_d;
        end
    end

    assign mode_o  = mode_q;
    assign flash_o = flash_q;

endmodule
`default_nettype wire

// File: rtl/ghost_state.sv
`default_nettype none
// ============================================================================
// Module   : ghost_state -- per-ghost position, heading, mode and animation
// Options  : GHOST_REVERSE_EN reverses heading on entry to frightened mode
// Revision : 1.0 initial release
// ============================================================================
module ghost_state
    import ghost_pkg::*;
#(
    parameter logic [9:0] START_X      = 10'd320,
    parameter logic [9:0] START_Y      = 10'd240,
    parameter logic [9:0] HOME_X       = 10'd320,
    parameter logic [9:0] HOME_Y       = 10'd224,
    parameter logic [9:0] X_MAX        = 10'd639,
    parameter int         STEP_FRAMES  = 2,
    parameter int         FRGT_FRAMES  = 360,
    parameter int         FLASH_START  = 120,
    parameter int         FLASH_PERIOD = 16,
    parameter int         SCOR_FRAMES  = 60,
    parameter int         ANIM_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [1:0]  dir_req,
    input  logic        dir_valid,
    input  logic [3:0]  blocked,
    input  logic        power_pellet,
    input  logic        eaten,
    output logic [24:0] ghost_inputs,
    output logic        animation_cycle
);

    localparam int STEP_W = $clog2(2 * STEP_FRAMES + 1);
    localparam int ANIM_W = $clog2(ANIM_FRAMES + 1);

    localparam logic [STEP_W-1:0] C_PER_NORM  = STEP_W'(STEP_FRAMES);
    localparam logic [STEP_W-1:0] C_PER_FRGT  = STEP_W'(2 * STEP_FRAMES);
    localparam logic [STEP_W-1:0] C_PER_DEAD  = STEP_W'(1);
    localparam logic [ANIM_W-1:0] C_ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

    logic [9:0]        x_q,        x_d;
    logic [9:0]        y_q,        y_d;
    logic [1:0]        dir_q,      dir_d;
    logic [1:0]        next_dir_q, next_dir_d;
    logic [STEP_W-1:0] step_q,     step_d;
    logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
    logic              anim_q,     anim_d;

    logic [1:0]        w_mode;
    logic              w_flash;
    logic              w_mode_changed;
    logic [STEP_W-1:0] w_period;
    logic [STEP_W-1:0] w_step_inc;
    logic              w_step_hit;
    logic [1:0]        w_head;
    logic              w_go;
    logic [9:0]        w_x_mv;
    logic [9:0]        w_y_mv;
    logic              w_at_home;

    ghost_mode_fsm #(
        .FRGT_FRAMES  (FRGT_FRAMES),
        .FLASH_START  (FLASH_START),
        .FLASH_PERIOD (FLASH_PERIOD),
        .SCOR_FRAMES  (SCOR_FRAMES)
    ) u_mode_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick_i   (frame_tick),
        .power_pellet_i (power_pellet),
        .eaten_i        (eaten),
        .at_home_i      (w_at_home),
        .mode_o         (w_mode),
        .flash_o        (w_flash),
        .mode_changed_o (w_mode_changed)
    );

    // Candidate move for this frame; the FSM needs the post-move position.
    always_comb begin
        case (w_mode)
            C_MODE_FRGT: w_period = C_PER_FRGT;
            C_MODE_DEAD: w_period = C_PER_DEAD;
            default:     w_period = C_PER_NORM;
        endcase
        w_step_inc = step_q + 1'b1;
        w_step_hit = (w_mode != C_MODE_SCOR) && (w_step_inc == w_period);

        if (w_mode == C_MODE_DEAD) begin
            if (x_q != HOME_X) begin
                w_head = (x_q < HOME_X) ? C_DIR_RT : C_DIR_LT;
            end else begin
                w_head = (y_q < HOME_Y) ? C_DIR_DN : C_DIR_UP;
            end
            w_go = (x_q != HOME_X) || (y_q != HOME_Y);
        end else begin
            w_head = blocked[next_dir_q] ? dir_q : next_dir_q;
            w_go   = !blocked[w_head];
        end

        w_x_mv = x_q;
        w_y_mv = y_q;
        if (w_step_hit && w_go) begin
            case (w_head)
                C_DIR_RT: w_x_mv = (x_q == X_MAX) ? 10'd0 : x_q + 10'd1;
                C_DIR_LT: w_x_mv = (x_q == 10'd0) ? X_MAX : x_q - 10'd1;
                C_DIR_UP: w_y_mv = y_q - 10'd1;
                default:  w_y_mv = y_q + 10'd1;
            endcase
        end
        w_at_home = (w_x_mv == HOME_X) && (w_y_mv == HOME_Y);
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        step_d     = step_q;
        anim_cnt_d = anim_cnt_q;
        anim_d     = anim_q;
        next_dir_d = dir_valid ? dir_req : next_dir_q;

        if (frame_tick) begin
            x_d = w_x_mv;
            y_d = w_y_mv;
            if (w_step_hit) begin
                dir_d = w_head;
            end
            if (w_step_hit || w_mode_changed || (w_mode == C_MODE_SCOR)) begin
                step_d = '0;
            end else begin
                step_d = w_step_inc;
            end
            if (w_mode_changed && (w_mode == C_MODE_DEAD)) begin
                dir_d = C_DIR_UP;
            end
`ifdef GHOST_REVERSE_EN
            // NORM only ever leaves for FRGT; the reversal replaces this frame's move.
            if (w_mode_changed && (w_mode == C_MODE_NORM)) begin
                x_d        = x_q;
                y_d        = y_q;
                dir_d      = opposite_dir(dir_q);
                next_dir_d = opposite_dir(dir_q);
            end
`else
            // Heading is carried unchanged into frightened mode.
`endif
            if (anim_cnt_q == C_ANIM_LAST) begin
                anim_cnt_d = '0;
                anim_d     = ~anim_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q        <= START_X;
            y_q        <= START_Y;
            dir_q      <= C_DIR_LT;
            next_dir_q <= C_DIR_LT;
            step_q     <= '0;
            anim_cnt_q <= '0;
            anim_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            next_dir_q <= next_dir_d;
            step_q     <= step_d;
            anim_cnt_q <= anim_cnt_d;
            anim_q     <= anim_d;
        end
    end

    assign ghost_inputs    = ghost_inputs_t'{x: x_q, y: y_q, dir: dir_q, mode: w_mode, flash: w_flash};
    assign animation_cycle = anim_q;

endmodule
`default_nettype wire

// File: tb/tb_ghost_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_state -- self-checking bench for ghost_state
// Revision : 1.0 initial release
// ============================================================================
module tb_ghost_state;

    localparam logic [1:0] NORM = 2'd0, FRGT = 2'd1, SCOR = 2'd2, DEAD = 2'd3;
    localparam logic [1:0] RT = 2'd0, UP = 2'd1, DN = 2'd2, LT = 2'd3;
    localparam int HOME_X = 320, HOME_Y = 224, X_MAX = 639;
    localparam int STEP = 2, FRGT_FRAMES = 360, FLASH_START = 120, FLASH_PERIOD = 16;
    localparam int SCOR_FRAMES = 60, ANIM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  dir_req = 2'd0;
    logic        dir_valid = 1'b0;
    logic [3:0]  blocked = 4'd0;
    logic        power_pellet = 1'b0;
    logic        eaten = 1'b0;
    logic [24:0] ghost_inputs;
    logic        animation_cycle;

    int n_total = 0;
    int n_bad   = 0;

    ghost_state dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .dir_req         (dir_req),
        .dir_valid       (dir_valid),
        .blocked         (blocked),
        .power_pellet    (power_pellet),
        .eaten           (eaten),
        .ghost_inputs    (ghost_inputs),
        .animation_cycle (animation_cycle)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Reference model: game state in plain integers, stepped once per frame.
    int         m_x, m_y, m_phase, m_fleft, m_sleft, m_ticks;
    logic [1:0] m_dir, m_nd, m_mode;
    bit         m_pp, m_pe;

    task automatic model_reset();
        m_x = 320; m_y = 240; m_dir = LT; m_nd = LT; m_mode = NORM;
        m_phase = 0; m_fleft = 0; m_sleft = 0; m_ticks = 0; m_pp = 0; m_pe = 0;
    endtask

    task automatic model_move(input logic [1:0] d);
        case (d)
            RT: m_x = (m_x + 1) % (X_MAX + 1);
            LT: m_x = (m_x + X_MAX) % (X_MAX + 1);
            UP: m_y = (m_y + 1023) % 1024;
            default: m_y = (m_y + 1) % 1024;
        endcase
    endtask

    task automatic model_frame();
        int period;
        logic [1:0] old;
`ifdef GHOST_REVERSE_EN
        int px, py;
        px = m_x; py = m_y;
`endif
        old = m_mode;
        m_ticks++;
        if (m_mode != SCOR) begin
            period = (m_mode == NORM) ? STEP : (m_mode == FRGT) ? 2 * STEP : 1;
            m_phase++;
            if (m_phase == period) begin
                m_phase = 0;
                if (m_mode == DEAD) begin
                    if (m_x != HOME_X) m_dir = (m_x < HOME_X) ? RT : LT;
                    else               m_dir = (m_y < HOME_Y) ? DN : UP;
                    if (m_x != HOME_X || m_y != HOME_Y) model_move(m_dir);
                end else begin
                    if (!blocked[m_nd]) m_dir = m_nd;
                    if (!blocked[m_dir]) model_move(m_dir);
                end
            end
        end
        case (old)
            NORM: if (m_pp) begin m_mode = FRGT; m_fleft = FRGT_FRAMES; end
            FRGT: begin
                if (m_pe) begin m_mode = SCOR; m_sleft = SCOR_FRAMES; end
                else if (m_pp) m_fleft = FRGT_FRAMES;
                else if (m_fleft == 1) m_mode = NORM;
                else m_fleft--;
            end
            SCOR: if (m_sleft == 1) m_mode = DEAD; else m_sleft--;
            default: if (m_x == HOME_X && m_y == HOME_Y) begin m_mode = NORM; m_dir = UP; end
        endcase
        if (m_mode != old) m_phase = 0;
`ifdef GHOST_REVERSE_EN
        if (old == NORM && m_mode == FRGT) begin
            m_x = px; m_y = py; m_dir = 2'd3 - m_dir; m_nd = m_dir;
        end
`endif
        m_pp = 0; m_pe = 0;
    endtask

    function automatic logic [25:0] m_exp();
        logic fl;
        fl = (m_mode == FRGT) && (m_fleft <= FLASH_START) &&
             (((FLASH_START - m_fleft) / FLASH_PERIOD) % 2 == 0);
        return {10'(m_x), 10'(m_y), m_dir, m_mode, fl, ((m_ticks / ANIM) % 2) == 1};
    endfunction

    // Stimulus primitives; all driving happens on the falling edge.
    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        model_frame();
    endtask

    task automatic pulse(input bit pp, input bit pe);
        @(negedge clk); power_pellet = pp; eaten = pe;
        @(negedge clk); power_pellet = 1'b0; eaten = 1'b0;
        if (pp) m_pp = 1;
        if (pe) m_pe = 1;
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk); dir_req = d; dir_valid = 1'b1;
        @(negedge clk); dir_valid = 1'b0;
        m_nd = d;
    endtask

    task automatic test_reset();
        logic [25:0] exp;
        blocked = 4'd0;
        do_reset();
        exp = {10'd320, 10'd240, LT, NORM, 1'b0, 1'b0};
        if ({ghost_inputs, animation_cycle} !== exp) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", {ghost_inputs, animation_cycle}, exp);
        end
        n_total++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ({ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL reset_ticks[%0d]: got %h expected %h", i, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
        exp = {10'd318, 10'd240, LT, NORM, 1'b0, 1'b0};
        if ({ghost_inputs, animation_cycle} !== exp) begin
            n_bad++;
            $display("FAIL four_ticks: got %h expected %h", {ghost_inputs, animation_cycle}, exp);
        end
        n_total++;
    endtask

    task automatic test_dir_block();
        blocked = 4'b0010;
        set_dir(UP);
        tick(); tick();
        if (ghost_inputs[4:3] !== LT) begin
            n_bad++;
            $display("FAIL blocked_dir: got %0d expected %0d", ghost_inputs[4:3], LT);
        end
        n_total++;
        blocked = 4'b0000;
        tick(); tick();
        if (ghost_inputs[4:3] !== UP || ghost_inputs[14:5] !== 10'd239) begin
            n_bad++;
            $display("FAIL turn_up: got dir=%0d y=%0d expected dir=1 y=239", ghost_inputs[4:3], ghost_inputs[14:5]);
        end
        n_total++;
        if ({ghost_inputs, animation_cycle} !== m_exp()) begin
            n_bad++;
            $display("FAIL turn_model: got %h expected %h", {ghost_inputs, animation_cycle}, m_exp());
        end
        n_total++;
    endtask

    task automatic test_wrap();
        blocked = 4'd0;
        do_reset();
        for (int i = 0; i < 640; i++) begin
            tick();
            if ({ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL walk_left[%0d]: got %h expected %h", i, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
        if (ghost_inputs[24:15] !== 10'd0) begin
            n_bad++;
            $display("FAIL reach_zero: got x=%0d expected x=0", ghost_inputs[24:15]);
        end
        n_total++;
        tick(); tick();
        if (ghost_inputs[24:15] !== 10'd639 || {ghost_inputs, animation_cycle} !== m_exp()) begin
            n_bad++;
            $display("FAIL wrap_left: got x=%0d expected x=639", ghost_inputs[24:15]);
        end
        n_total++;
        set_dir(RT);
        tick(); tick();
        if (ghost_inputs[24:15] !== 10'd0 || ghost_inputs[4:3] !== RT) begin
            n_bad++;
            $display("FAIL wrap_right: got x=%0d dir=%0d expected x=0 dir=0", ghost_inputs[24:15], ghost_inputs[4:3]);
        end
        n_total++;
    endtask

    task automatic test_frightened();
        logic [2:0] exp_mf;
        blocked = 4'd0;
        do_reset();
        pulse(1, 0);
        tick();
        if (ghost_inputs[2:1] !== FRGT) begin
            n_bad++;
            $display("FAIL enter_frgt: got mode=%0d expected mode=1", ghost_inputs[2:1]);
        end
        n_total++;
        for (int k = 1; k <= 360; k++) begin
            tick();
            exp_mf = {(k < 360) ? FRGT : NORM,
                      (k >= 240) && (k < 360) && (((k - 240) / 16) % 2 == 0)};
            if (ghost_inputs[2:0] !== exp_mf) begin
                n_bad++;
                $display("FAIL frgt_flash[%0d]: got mode/flash=%b expected %b", k, ghost_inputs[2:0], exp_mf);
            end
            n_total++;
            if ({ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL frgt_model[%0d]: got %h expected %h", k, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
    endtask

    task automatic test_eaten_dead();
        int guard;
        blocked = 4'd0;
        do_reset();
        pulse(1, 0);
        tick();
        repeat (10) tick();
        pulse(1, 1);
        tick();
        if (ghost_inputs[2:1] !== SCOR) begin
            n_bad++;
            $display("FAIL eat_wins: got mode=%0d expected mode=2", ghost_inputs[2:1]);
        end
        n_total++;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ghost_inputs[2:1] !== ((k < 60) ? SCOR : DEAD) || {ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL score_hold[%0d]: got %h expected %h", k, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
        guard = 0;
        while (ghost_inputs[2:1] == DEAD && guard < 1000) begin
            tick();
            guard++;
            if ({ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL dead_path[%0d]: got %h expected %h", guard, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
        if (ghost_inputs[24:1] !== {10'd320, 10'd224, UP, NORM}) begin
            n_bad++;
            $display("FAIL dead_home: got x=%0d y=%0d dir=%0d mode=%0d after %0d ticks expected 320 224 1 0",
                     ghost_inputs[24:15], ghost_inputs[14:5], ghost_inputs[4:3], ghost_inputs[2:1], guard);
        end
        n_total++;
    endtask

    task automatic test_reset_mid_dead();
        logic [25:0] exp;
        blocked = 4'd0;
        do_reset();
        pulse(1, 0);
        tick();
        pulse(0, 1);
        tick();
        repeat (62) tick();
        if (ghost_inputs[2:1] !== DEAD) begin
            n_bad++;
            $display("FAIL reach_dead: got mode=%0d expected mode=3", ghost_inputs[2:1]);
        end
        n_total++;
        pulse(1, 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        exp = {10'd320, 10'd240, LT, NORM, 1'b0, 1'b0};
        if ({ghost_inputs, animation_cycle} !== exp) begin
            n_bad++;
            $display("FAIL mid_dead_reset: got %h expected %h", {ghost_inputs, animation_cycle}, exp);
        end
        n_total++;
        tick();
        if (ghost_inputs[2:1] !== NORM || {ghost_inputs, animation_cycle} !== m_exp()) begin
            n_bad++;
            $display("FAIL pend_cleared: got %h expected %h", {ghost_inputs, animation_cycle}, m_exp());
        end
        n_total++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            blocked = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_dir(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 39) == 0) pulse(1, 0);
            if ($urandom_range(0, 49) == 0) pulse($urandom_range(0, 1) == 1, 1);
            tick();
            if ({ghost_inputs, animation_cycle} !== m_exp()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h expected %h", i, {ghost_inputs, animation_cycle}, m_exp());
            end
            n_total++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dir_block();
        test_wrap();
        test_frightened();
        test_eaten_dead();
        test_reset_mid_dead();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
